// File: rtl/snake_step_sched.sv
// Per-tick step sequencer: advance head, run collision check, commit step to body FIFO.
module snake_step_sched #(
  parameter int unsigned POS_W     = 4,
  parameter int unsigned MAX_LEN   = 32,
  parameter int unsigned INIT_LEN  = 3,
  parameter int unsigned GROW_STEP = 1,
  parameter int unsigned CHK_TMO   = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [POS_W-1:0] head_x,
  input  logic [POS_W-1:0] head_y,
  input  logic [POS_W-1:0] food_x,
  input  logic [POS_W-1:0] food_y,
  input  logic             chk_done,
  input  logic             hit,
  output logic             lock,
  output logic             move_en,
  output logic             chk_start,
  output logic             push,
  output logic             pop,
  output logic             food_req,
  output logic [7:0]       len,
  output logic             game_over,
  output logic             tick_miss
);

  localparam int unsigned TMO_W = $clog2(CHK_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CHK_TMO - 1);
  localparam logic [7:0] MAX_L8  = 8'(MAX_LEN);
  localparam logic [7:0] INIT_P8 = 8'(INIT_LEN - 1);
  localparam logic [9:0] GROW10  = 10'(GROW_STEP);

  typedef enum logic [2:0] {
    S_IDLE, S_MOVE, S_WAIT, S_CHECK, S_COMMIT, S_DEAD
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       pend_q, pend_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             miss_q, miss_d;

  logic             eat;
  logic             pop_c;
  logic [9:0]       pend_sum;
  logic [7:0]       len_inc;

  // State and counters; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= 8'd1;
      pend_q  <= INIT_P8;
      tmo_q   <= '0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pend_q  <= pend_d;
      tmo_q   <= tmo_d;
      miss_q  <= miss_d;
    end
  end

  // Next-state, growth bookkeeping and step strobes.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    pend_d    = pend_q;
    tmo_d     = tmo_q;
    miss_d    = miss_q;
    lock      = 1'b0;
    move_en   = 1'b0;
    chk_start = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    food_req  = 1'b0;
    eat       = ({head_x, head_y} == {food_x, food_y});
    pop_c     = (pend_q == 8'd0);
    pend_sum  = {2'b00, pend_q} - {9'd0, ~pop_c} + (eat ? GROW10 : 10'd0);
    len_inc   = len_q + {7'd0, ~pop_c};

    if (tick && (state_q != S_IDLE) && (state_q != S_DEAD)) miss_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (tick) state_d = S_MOVE;
      end
      S_MOVE: begin
        move_en = 1'b1;
        lock    = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        chk_start = 1'b1;
        lock      = 1'b1;
        tmo_d     = '0;
        state_d   = S_CHECK;
      end
      S_CHECK: begin
        lock = 1'b1;
        if (chk_done)               state_d = hit ? S_DEAD : S_COMMIT;
        else if (tmo_q == TMO_LAST) state_d = S_DEAD;
        else                        tmo_d   = tmo_q + 1'b1;
      end
      S_COMMIT: begin
        push     = 1'b1;
        lock     = 1'b1;
        pop      = pop_c;
        food_req = eat;
        pend_d   = (pend_sum > 10'd255) ? 8'hFF : pend_sum[7:0];
        if (len_inc >= MAX_L8) begin
          len_d   = MAX_L8;
          state_d = S_DEAD;
        end else begin
          len_d   = len_inc;
          state_d = S_IDLE;
        end
      end
      S_DEAD: begin
        state_d = S_DEAD;
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are suppressed while reset is held so a mid-step reset cannot emit a push/pop.
    if (!reset) begin
      lock      = 1'b0;
      move_en   = 1'b0;
      chk_start = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      food_req  = 1'b0;
    end
  end

  assign len       = len_q;
  assign game_over = (state_q == S_DEAD);
  assign tick_miss = miss_q;

endmodule

// File: tb/tb_snake_step_sched.sv
// Randomized bench for snake_step_sched: two instances (MAX_LEN 32 and 4) checked against
// a step-level model of length, pending growth and game state.
module tb_snake_step_sched;

  localparam int POS_W   = 4;
  localparam int CHK_TMO = 15;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             tick = 1'b0;
  logic [POS_W-1:0] head_x = '0, head_y = '0, food_x = '0, food_y = '0;
  logic             chk_done = 1'b0, hit = 1'b0;

  logic       lk[2], mv[2], cs[2], ps[2], pp[2], fr[2], go[2], tm[2];
  logic [7:0] ln[2];

  always #5 clk = ~clk;

  snake_step_sched #(.POS_W(POS_W), .MAX_LEN(32), .INIT_LEN(3), .GROW_STEP(1), .CHK_TMO(CHK_TMO)) u_a (
    .clk(clk), .reset(reset), .tick(tick), .head_x(head_x), .head_y(head_y),
    .food_x(food_x), .food_y(food_y), .chk_done(chk_done), .hit(hit),
    .lock(lk[0]), .move_en(mv[0]), .chk_start(cs[0]), .push(ps[0]), .pop(pp[0]),
    .food_req(fr[0]), .len(ln[0]), .game_over(go[0]), .tick_miss(tm[0]));

  snake_step_sched #(.POS_W(POS_W), .MAX_LEN(4), .INIT_LEN(3), .GROW_STEP(1), .CHK_TMO(CHK_TMO)) u_b (
    .clk(clk), .reset(reset), .tick(tick), .head_x(head_x), .head_y(head_y),
    .food_x(food_x), .food_y(food_y), .chk_done(chk_done), .hit(hit),
    .lock(lk[1]), .move_en(mv[1]), .chk_start(cs[1]), .push(ps[1]), .pop(pp[1]),
    .food_req(fr[1]), .len(ln[1]), .game_over(go[1]), .tick_miss(tm[1]));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Cycle counter and per-step event monitor
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_mv[2], n_cs[2], n_ps[2], n_pp[2], n_fr[2], n_lone[2], push_cyc[2], dead_cyc[2];
  logic prev_go[2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mv[i]) n_mv[i]++;
      if (cs[i]) n_cs[i]++;
      if (ps[i]) begin n_ps[i]++; push_cyc[i] = cyc; end
      if (pp[i]) n_pp[i]++;
      if (fr[i]) n_fr[i]++;
      if ((pp[i] || fr[i]) && !ps[i]) n_lone[i]++;
      if (go[i] && !prev_go[i]) dead_cyc[i] = cyc;
      prev_go[i] = go[i];
    end
  end

  // Reference model state
  int m_len[2], m_pend[2];
  bit m_dead[2], m_miss[2];
  int m_max[2] = '{32, 4};

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      n_mv[i] = 0; n_cs[i] = 0; n_ps[i] = 0; n_pp[i] = 0; n_fr[i] = 0; n_lone[i] = 0;
      push_cyc[i] = -1; dead_cyc[i] = -1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_len[i] = 1; m_pend[i] = 2; m_dead[i] = 1'b0; m_miss[i] = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b0; tick = 1'b0; chk_done = 1'b0; hit = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("rst_len[%0d]", i), int'(ln[i]), 1);
      check_eq($sformatf("rst_go[%0d]", i), int'(go[i]), 0);
      check_eq($sformatf("rst_miss[%0d]", i), int'(tm[i]), 0);
      check_eq($sformatf("rst_lock[%0d]", i), int'(lk[i]), 0);
      check_eq($sformatf("rst_push[%0d]", i), int'(ps[i]), 0);
    end
  endtask

  // One game step. lat = cycles spent in CHECK before chk_done (0 = never answer).
  task automatic do_step(input bit hitv, input bit eat, input int lat, input bit dbl);
    int tcyc, nwait, e_ps, e_pp, e_fr, e_dc;
    bit was_dead;
    logic [7:0] r;
    clear_counts();
    @(posedge clk); #1;
    tick = 1'b1; tcyc = cyc;
    {food_x, food_y} = 8'($urandom);
    @(posedge clk); #1;
    tick = dbl;
    for (int i = 0; i < 2; i++)
      check_eq($sformatf("lock[%0d]", i), int'(lk[i]), m_dead[i] ? 0 : 1);
    @(posedge clk); #1;
    tick = 1'b0;
    r = 8'($urandom_range(1, 255));
    if (eat) {head_x, head_y} = {food_x, food_y};
    else     {head_x, head_y} = {food_x, food_y} ^ r;
    nwait = (lat == 0) ? CHK_TMO + 2 : lat;
    for (int k = 1; k <= nwait; k++) begin
      @(posedge clk); #1;
      if (k == lat) begin chk_done = 1'b1; hit = hitv; end
      else          begin chk_done = 1'b0; hit = 1'($urandom); end
    end
    @(posedge clk); #1;
    chk_done = 1'b0; hit = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 2; i++) begin
      was_dead = m_dead[i];
      e_ps = 0; e_pp = 0; e_fr = 0; e_dc = -1;
      if (!was_dead) begin
        if (dbl) m_miss[i] = 1'b1;
        if (lat == 0) begin
          m_dead[i] = 1'b1; e_dc = tcyc + 3 + CHK_TMO;
        end else if (hitv) begin
          m_dead[i] = 1'b1; e_dc = tcyc + 3 + lat;
        end else begin
          e_ps = 1;
          e_pp = (m_pend[i] == 0) ? 1 : 0;
          if (e_pp == 0) begin m_len[i]++; m_pend[i]--; end
          if (eat) begin
            e_fr = 1;
            m_pend[i] = (m_pend[i] + 1 > 255) ? 255 : m_pend[i] + 1;
          end
          if (m_len[i] >= m_max[i]) begin m_dead[i] = 1'b1; e_dc = tcyc + 4 + lat; end
          check_eq($sformatf("push_lat[%0d]", i), push_cyc[i] - tcyc, 3 + lat);
        end
      end
      check_eq($sformatf("move_en[%0d]", i), n_mv[i], was_dead ? 0 : 1);
      check_eq($sformatf("chk_start[%0d]", i), n_cs[i], was_dead ? 0 : 1);
      check_eq($sformatf("push[%0d]", i), n_ps[i], e_ps);
      check_eq($sformatf("pop[%0d]", i), n_pp[i], e_pp);
      check_eq($sformatf("food_req[%0d]", i), n_fr[i], e_fr);
      check_eq($sformatf("stray_strobe[%0d]", i), n_lone[i], 0);
      check_eq($sformatf("len[%0d]", i), int'(ln[i]), m_len[i]);
      check_eq($sformatf("game_over[%0d]", i), int'(go[i]), int'(m_dead[i]));
      check_eq($sformatf("tick_miss[%0d]", i), int'(tm[i]), int'(m_miss[i]));
      if (e_dc >= 0) check_eq($sformatf("dead_cyc[%0d]", i), dead_cyc[i] - tcyc, e_dc - tcyc);
    end
  endtask

  initial begin
    model_reset();
    clear_counts();
    apply_reset();

    // Initial growth: pop withheld for the first two steps
    repeat (3) do_step(1'b0, 1'b0, 1, 1'b0);
    // Eat, then a growth step (small instance reaches MAX_LEN=4 here)
    do_step(1'b0, 1'b1, 2, 1'b0);
    do_step(1'b0, 1'b0, 1, 1'b0);

    // Randomized steps without collisions
    for (int n = 0; n < 20; n++)
      do_step(1'b0, ($urandom_range(0, 2) == 0), int'($urandom_range(1, 4)), 1'b0);

    // Collision kills; later ticks are ignored
    do_step(1'b1, 1'b0, int'($urandom_range(1, 4)), 1'b0);
    do_step(1'b0, 1'b0, 1, 1'b0);
    do_step(1'b0, 1'b1, 2, 1'b1);
    apply_reset();

    // Checker never answers
    do_step(1'b0, 1'b0, 0, 1'b0);
    apply_reset();

    // Second tick while a step is in flight
    do_step(1'b0, 1'b0, 2, 1'b1);
    do_step(1'b0, 1'b0, 1, 1'b0);
    apply_reset();

    // Reset while in CHECK
    clear_counts();
    @(posedge clk); #1; tick = 1'b1;
    @(posedge clk); #1; tick = 1'b0;
    @(posedge clk); #1; {head_x, head_y} = 8'h12; {food_x, food_y} = 8'h34;
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("midrst_lock[%0d]", i), int'(lk[i]), 0);
      check_eq($sformatf("midrst_len[%0d]", i), int'(ln[i]), 1);
    end
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("midrst_move[%0d]", i), n_mv[i], 1);
      check_eq($sformatf("midrst_push[%0d]", i), n_ps[i], 0);
      check_eq($sformatf("midrst_pop[%0d]", i), n_pp[i], 0);
      check_eq($sformatf("midrst_go[%0d]", i), int'(go[i]), 0);
    end
    model_reset();
    do_step(1'b0, 1'b0, 3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
